img2col_seq: RTL and testbench

Sequencer for the img2col mapping datapath of the CNN accelerator. It accepts one pixel per handshake from the AXI-side source and drives the line-buffer write address and line select. It tracks the row and column position in the frame and raises a window-valid strobe with the window column number whenever a complete K×K window is resident. It sits between the AXI input adapter and the img2col register array, and throttles the source when the downstream systolic array back-pressures.

---
 rtl/img2col_pkg.sv | 22 ++
 rtl/img2col_seq_mod_cnt.sv | 31 +++
 rtl/img2col_seq.sv | 182 ++++++++++++++++++
 tb/tb_img2col_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/img2col_pkg.sv
// Shared types and default constants for the img2col mapping path.
// Used by img2col_seq, its mod_cnt counters and the img2col datapath.
package img2col_pkg;

  // Sequencer states, exposed for debug through img2col_seq.dbg_state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Default frame and kernel geometry.
  localparam int IMG_ROW    = 28;
  localparam int KERNEL     = 5;
  localparam int DATA_WIDTH = 16;

  // Number of K x K windows in a square frame of side row.
  function automatic int win_per_frame(input int row, input int k);
    return (row - k + 1) * (row - k + 1);
  endfunction

endpackage

// File: rtl/img2col_seq_mod_cnt.sv
// Modulo-N up counter with synchronous clear and a wrap strobe.
// o_wrap is high in the cycle where an enabled count rolls from N-1 to 0.
module mod_cnt #(
  parameter int N = 28,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  logic [W-1:0] r_count;

  assign o_wrap  = i_en && (r_count == W'(N - 1));
  assign o_count = r_count;

  // Clear has priority over counting; enabled count wraps at N-1.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_wrap ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/img2col_seq.sv
// img2col_seq: pixel sequencer for the img2col line buffers.
// Accepts one pixel per in_valid/in_ready handshake, drives the line-buffer
// write address / line select, and presents one K x K window at a time.
// Optional feature macro: IMG2COL_SEQ_PERF_EN adds the perf_stall counter.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid, once raised, holds its payload stable until that edge,
// and ready may depend combinationally on the downstream ready only.
module img2col_seq
  import img2col_pkg::*;
#(
  parameter int ROW    = IMG_ROW,
  parameter int K      = KERNEL,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 10
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [$clog2(K)-1:0] line_sel,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [ADDR_W-1:0]    col_num,
  output logic [ADDR_W-1:0]    win_row,
  output logic                 busy,
  output logic                 done,
`ifdef IMG2COL_SEQ_PERF_EN
  output logic [31:0]          perf_stall,
`endif
  output logic [1:0]           dbg_state
);

  localparam int LS_W = $clog2(K);
  localparam logic [ADDR_W-1:0] KM1  = ADDR_W'(K - 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROW - K);

  seq_state_e r_state;
  seq_state_e w_next_state;

  logic              w_run_entry;
  logic              w_hs;
  logic              w_win_hs;
  logic              w_win_load;
  logic              w_last_win;
  logic              w_col_wrap;
  logic              w_row_wrap;
  logic              w_ls_wrap;
  logic [ADDR_W-1:0] w_col;
  logic [ADDR_W-1:0] w_row;
  logic [LS_W-1:0]   w_line_sel;

  logic              r_win_valid;
  logic [ADDR_W-1:0] r_col_num;
  logic [ADDR_W-1:0] r_win_row;
  logic [CNT_W-1:0]  r_win_cnt;

  // Wrap strobes of row / line_sel and the window count are observation only.
  logic w_unused;
  assign w_unused = &{1'b0, w_row_wrap, w_ls_wrap, r_win_cnt};

  // Handshake and window bookkeeping.
  assign w_run_entry = (r_state == IDLE) && start;
  assign in_ready    = (r_state == RUN) && (!r_win_valid || win_ready);
  assign w_hs        = in_valid && in_ready;
  assign w_win_hs    = r_win_valid && win_ready;
  // Comparisons gate the subtractions below, so col/row never underflow.
  assign w_win_load  = w_hs && (w_row >= KM1) && (w_col >= KM1);
  assign w_last_win  = w_win_hs && (r_win_row == LAST) && (r_col_num == LAST);

  // Column position inside the current row; doubles as write address.
  mod_cnt #(.N(ROW), .W(ADDR_W)) u_col_cnt (
    .clk     (clk),
    .nrst    (nrst),
    .i_clr   (w_run_entry),
    .i_en    (w_hs),
    .o_count (w_col),
    .o_wrap  (w_col_wrap)
  );

  // Row position inside the frame.
  mod_cnt #(.N(ROW), .W(ADDR_W)) u_row_cnt (
    .clk     (clk),
    .nrst    (nrst),
    .i_clr   (w_run_entry),
    .i_en    (w_col_wrap),
    .o_count (w_row),
    .o_wrap  (w_row_wrap)
  );

  // Line buffer selection, row mod K.
  mod_cnt #(.N(K), .W(LS_W)) u_line_cnt (
    .clk     (clk),
    .nrst    (nrst),
    .i_clr   (w_run_entry),
    .i_en    (w_col_wrap),
    .o_count (w_line_sel),
    .o_wrap  (w_ls_wrap)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (w_last_win) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Window register: loading wins over consuming, giving a one-deep skid.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_win_valid <= 1'b0;
      r_col_num   <= '0;
      r_win_row   <= '0;
    end else if (w_run_entry) begin
      r_win_valid <= 1'b0;
      r_col_num   <= '0;
      r_win_row   <= '0;
    end else if (w_win_load) begin
      r_win_valid <= 1'b1;
      r_col_num   <= w_col - KM1;
      r_win_row   <= w_row - KM1;
    end else if (w_win_hs) begin
      r_win_valid <= 1'b0;
    end
  end

  // Count of windows consumed in the current frame.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_win_cnt <= '0;
    end else if (w_run_entry) begin
      r_win_cnt <= '0;
    end else if (w_win_hs) begin
      r_win_cnt <= r_win_cnt + CNT_W'(1);
    end
  end

`ifdef IMG2COL_SEQ_PERF_EN
  logic [31:0] r_perf_stall;

  // Stalled-source cycles in RUN, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_perf_stall <= '0;
    end else if (w_run_entry) begin
      r_perf_stall <= '0;
    end else if ((r_state == RUN) && in_valid && !in_ready &&
                 (r_perf_stall != '1)) begin
      r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_stall = r_perf_stall;
`endif

  assign wr_en     = w_hs;
  assign wr_addr   = w_col;
  assign line_sel  = w_line_sel;
  assign win_valid = r_win_valid;
  assign col_num   = r_col_num;
  assign win_row   = r_win_row;
  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_img2col_seq.sv
// Directed bench for img2col_seq: reset, full frames, row wrap,
// back-pressure, start-in-RUN, mid-frame reset and (with
// IMG2COL_SEQ_PERF_EN) the stall counter.
module tb_img2col_seq;

  localparam int ROW    = 28;
  localparam int K      = 5;
  localparam int ADDR_W = 5;
  localparam int NWIN   = (ROW - K + 1) * (ROW - K + 1);

  // Clock / reset and DUT signals.
  logic              clk = 1'b0;
  logic              nrst;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        line_sel;
  logic              win_valid;
  logic              win_ready;
  logic [ADDR_W-1:0] col_num;
  logic [ADDR_W-1:0] win_row;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;
`ifdef IMG2COL_SEQ_PERF_EN
  logic [31:0]       perf_stall;
`endif

  always #5 clk = ~clk;

  img2col_seq dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .line_sel  (line_sel),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .col_num   (col_num),
    .win_row   (win_row),
    .busy      (busy),
    .done      (done),
`ifdef IMG2COL_SEQ_PERF_EN
    .perf_stall(perf_stall),
`endif
    .dbg_state (dbg_state)
  );

  // Scoreboard state.
  int n_checks = 0;
  int n_fail   = 0;
  int win_seen = 0;
  int done_cnt = 0;
  logic [2*ADDR_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Window monitor: every consumed window must be the next expected one.
  always @(negedge clk) begin
    if (nrst && win_valid && win_ready) begin
      win_seen++;
      check("win_q_nonempty", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check("win_pos", {win_row, col_num}, exp_q.pop_front());
      end
    end
    if (nrst && done) done_cnt++;
  end

  // Driver helpers.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_exp();
    exp_q.delete();
    win_seen = 0;
    done_cnt = 0;
    for (int r = 0; r <= ROW - K; r++)
      for (int c = 0; c <= ROW - K; c++)
        exp_q.push_back({ADDR_W'(r), ADDR_W'(c)});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_state", dbg_state, 2'd1);
  endtask

  task automatic send_pixels(input int first, input int last);
    for (int p = first; p <= last; p++) begin
      in_valid = 1'b1;
      #1;
      check("in_ready", in_ready, 1);
      check("wr_en", wr_en, 1);
      check("wr_addr", wr_addr, p % ROW);
      check("line_sel", line_sel, (p / ROW) % K);
      tick();
      if (p == 115) check("no_win_before_116", win_valid, 0);
      if (p == 116) begin
        check("first_win_valid", win_valid, 1);
        check("first_col_num", col_num, 0);
        check("first_win_row", win_row, 0);
      end
      if (p == 117) check("second_col_num", col_num, 1);
      if (p == 27) begin
        check("wrap_wr_addr", wr_addr, 0);
        check("wrap_line_sel", line_sel, 1);
      end
      if (p == 139) check("line_sel_mod_k", line_sel, 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic full_frame();
    load_exp();
    pulse_start();
    check("run_in_ready", in_ready, 1);
    send_pixels(0, ROW * ROW - 1);
    check("last_col_num", col_num, ROW - K);
    check("last_win_row", win_row, ROW - K);
    tick();
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_in_ready", in_ready, 0);
    tick();
    check("done_cleared", done, 0);
    check("back_idle", dbg_state, 2'd0);
    check("win_total", win_seen, NWIN);
    check("done_count", done_cnt, 1);
    check("win_q_drained", exp_q.size(), 0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    nrst      = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    win_ready = 1'b1;
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_line_sel", line_sel, 0);
    check("rst_win_valid", win_valid, 0);
    check("rst_col_num", col_num, 0);
    check("rst_win_row", win_row, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, 2'd0);
    nrst = 1'b1;
    tick();
    in_valid = 1'b1;
    #1;
    check("idle_no_accept", in_ready, 0);
    in_valid = 1'b0;

    // Frame 1: win_ready tied high, back-to-back pixels.
    full_frame();

    // Frame 2: back-pressure, start in RUN, reset mid-frame.
    load_exp();
    pulse_start();
    send_pixels(0, 116);
    win_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_wr_en", wr_en, 0);
      check("bp_win_valid", win_valid, 1);
      check("bp_col_num", col_num, 0);
      tick();
    end
    win_ready = 1'b1;
    send_pixels(117, 199);
    start = 1'b1;
    send_pixels(200, 200);
    start = 1'b0;
    check("start_in_run_state", dbg_state, 2'd1);
    check("start_in_run_addr", wr_addr, 201 % ROW);
    send_pixels(201, 299);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    check("mid_rst_state", dbg_state, 2'd0);
    check("mid_rst_win_valid", win_valid, 0);
    check("mid_rst_wr_addr", wr_addr, 0);
    check("mid_rst_line_sel", line_sel, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    exp_q.delete();

    // Frame 3: a clean frame after the aborted one.
    full_frame();

`ifdef IMG2COL_SEQ_PERF_EN
    // Stall counter: 7 blocked cycles with a waiting source.
    load_exp();
    pulse_start();
    check("perf_cleared", perf_stall, 0);
    send_pixels(0, 116);
    win_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("perf_stall", perf_stall, 7);
    in_valid  = 1'b0;
    win_ready = 1'b1;
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    exp_q.delete();
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
